// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data-path and RAM signals around mem_port_arbiter.
// slave is the arbiter's view; master is the surrounding core + RAM view.
interface mem_port_arbiter_if #(
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [DATA_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              cpu_stall;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy, cpu_stall
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy, cpu_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, fixed-latency RAM between instruction fetch and the
// data load/store path, sequencing one transaction at a time.
module mem_port_arbiter #(
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STARVE_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  if (MEM_LAT < 1) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [STARVE_W-1:0] starve_r;
  logic                owner_r;
  logic                if_gnt_r;
  logic                if_valid_r;
  logic [DATA_W-1:0]   if_rdata_r;
  logic                d_gnt_r;
  logic                d_valid_r;
  logic [DATA_W-1:0]   d_rdata_r;
  logic                mem_en_r;
  logic                mem_we_r;
  logic [DATA_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic                fetch_wins_s;

  // Data wins unless it is idle or fetch has been passed over STARVE_MAX times
  always_comb begin
    fetch_wins_s = 1'b0;
    if (!bus.d_req) begin
      fetch_wins_s = 1'b1;
    end else if (bus.if_req && (starve_r == STARVE_W'(STARVE_MAX))) begin
      fetch_wins_s = 1'b1;
    end else begin
      fetch_wins_s = 1'b0;
    end
  end

  // Transaction sequencer: arbitration, RAM drive and response capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      starve_r    <= {STARVE_W{1'b0}};
      owner_r     <= OWN_IF;
      if_gnt_r    <= 1'b0;
      if_valid_r  <= 1'b0;
      if_rdata_r  <= ZERO_D;
      d_gnt_r     <= 1'b0;
      d_valid_r   <= 1'b0;
      d_rdata_r   <= ZERO_D;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= ZERO_D;
      mem_wdata_r <= ZERO_D;
    end else begin
      if_gnt_r   <= 1'b0;
      d_gnt_r    <= 1'b0;
      if_valid_r <= 1'b0;
      d_valid_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.if_req || bus.d_req) begin
            state_r  <= ST_ACCESS;
            cnt_r    <= CNT_W'(MEM_LAT - 1);
            mem_en_r <= 1'b1;
            if (fetch_wins_s) begin
              owner_r     <= OWN_IF;
              if_gnt_r    <= 1'b1;
              mem_we_r    <= 1'b0;
              mem_addr_r  <= bus.if_addr;
              mem_wdata_r <= ZERO_D;
              starve_r    <= {STARVE_W{1'b0}};
            end else begin
              owner_r     <= OWN_D;
              d_gnt_r     <= 1'b1;
              mem_we_r    <= bus.d_we;
              mem_addr_r  <= bus.d_addr;
              mem_wdata_r <= bus.d_wdata;
              if (!bus.if_req) begin
                starve_r <= {STARVE_W{1'b0}};
              end else if (starve_r != STARVE_W'(STARVE_MAX)) begin
                starve_r <= starve_r + STARVE_W'(1);
              end else begin
                starve_r <= starve_r;
              end
            end
          end else begin
            state_r  <= ST_IDLE;
            starve_r <= {STARVE_W{1'b0}};
          end
        end
        ST_ACCESS: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            // Last RAM cycle: mem_rdata is valid now; stores return zero
            state_r  <= ST_RESP;
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
            if (owner_r == OWN_D) begin
              d_rdata_r <= mem_we_r ? ZERO_D : bus.mem_rdata;
              d_valid_r <= 1'b1;
            end else begin
              if_rdata_r <= bus.mem_rdata;
              if_valid_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r  <= ST_IDLE;
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_gnt    = if_gnt_r;
  assign bus.if_valid  = if_valid_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_gnt     = d_gnt_r;
  assign bus.d_valid   = d_valid_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.busy      = (state_r != ST_IDLE);
  assign bus.cpu_stall = (bus.if_req & ~if_valid_r) | (bus.d_req & ~d_valid_r);

endmodule
